// File: rtl/ram_read_arbiter_if.sv
// ram_read_arbiter_if: RAM read port, consumer request/grant and shared sample bus bundle
interface ram_read_arbiter_if #(
    parameter int N_CONS = 2,
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] ram_read_data_i;
    logic              ram_read_valid_i;
    logic              ram_read_ready_o;
    logic              ram_buffer_ready_i;
    logic [N_CONS-1:0] req_i;
    logic [N_CONS-1:0] grant_o;
    logic [DATA_W-1:0] data_o;
    logic [N_CONS-1:0] valid_o;
    logic [N_CONS-1:0] ready_i;
    logic              burst_done_o;
    logic              burst_abort_o;

    modport master (
        output ram_read_data_i, ram_read_valid_i, ram_buffer_ready_i, req_i, ready_i,
        input  ram_read_ready_o, grant_o, data_o, valid_o, burst_done_o, burst_abort_o
    );

    modport slave (
        input  ram_read_data_i, ram_read_valid_i, ram_buffer_ready_i, req_i, ready_i,
        output ram_read_ready_o, grant_o, data_o, valid_o, burst_done_o, burst_abort_o
    );
endinterface

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin burst arbiter sharing the ram_logic read port among consumers
module ram_read_arbiter #(
    parameter int N_CONS    = 2,
    parameter int DATA_W    = 24,
    parameter int BURST_LEN = 64,
    parameter int STALL_MAX = 1024
) (
    input logic               clk_i,
    input logic               rst_ni,
    ram_read_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_CONS);
    localparam int XW = $clog2(BURST_LEN + 1);
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_gnt_idx, w_gnt_nxt;
    logic [IW-1:0]     r_last_idx, w_last_nxt;
    logic [IW-1:0]     w_pick, w_cand;
    logic [XW-1:0]     r_xfer_cnt, w_xfer_nxt;
    logic [SW-1:0]     r_stall_cnt, w_stall_nxt;
    logic              r_done, w_done_nxt;
    logic              r_abort, w_abort_nxt;
    logic              w_xfer, w_full, w_wd, w_stall;
    logic [N_CONS-1:0] w_onehot;
    logic [DATA_W-1:0] w_data;

    assign w_onehot = N_CONS'(1) << r_gnt_idx;
    assign w_data   = bus.ram_read_data_i;
    assign w_xfer   = (r_state == GRANT) && bus.ram_read_valid_i && bus.ready_i[r_gnt_idx];
    assign w_full   = w_xfer && (r_xfer_cnt == XW'(BURST_LEN - 1));
    assign w_wd     = !w_xfer && !bus.req_i[r_gnt_idx];
    assign w_stall  = !w_xfer && bus.req_i[r_gnt_idx] && (r_stall_cnt == SW'(STALL_MAX - 1));

    // Round-robin search: walk downward so the nearest requester after last_idx wins
    always_comb begin
        w_pick = r_last_idx;
        w_cand = r_last_idx;
        for (int k = N_CONS; k >= 1; k--) begin
            w_cand = IW'((int'(r_last_idx) + k) % N_CONS);
            if (bus.req_i[w_cand]) w_pick = w_cand;
        end
    end

    // State register: all arbiter state and the registered burst-end pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_last_idx  <= IW'(N_CONS - 1);
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_idx   <= w_gnt_nxt;
            r_last_idx  <= w_last_nxt;
            r_xfer_cnt  <= w_xfer_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    // Next state: grant in IDLE, count beats/stalls in GRANT, release on full, withdraw or stall
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_last_nxt  = r_last_idx;
        w_xfer_nxt  = r_xfer_cnt;
        w_stall_nxt = r_stall_cnt;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (bus.ram_buffer_ready_i && |bus.req_i) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = w_pick;
                w_xfer_nxt  = '0;
                w_stall_nxt = '0;
            end
        end else begin
            w_xfer_nxt  = w_xfer ? r_xfer_cnt + XW'(1) : r_xfer_cnt;
            w_stall_nxt = w_xfer ? '0 : (r_stall_cnt == SW'(STALL_MAX)) ? r_stall_cnt : r_stall_cnt + SW'(1);
            if (w_full || w_wd || w_stall) begin
                w_state_nxt = IDLE;
                w_last_nxt  = r_gnt_idx;
                w_done_nxt  = w_full || w_wd;
                w_abort_nxt = w_stall;
            end
        end
    end

    // Outputs: pass the handshake through to the granted consumer only
    always_comb begin
        bus.grant_o          = (r_state == GRANT) ? w_onehot : '0;
        bus.valid_o          = (r_state == GRANT && bus.ram_read_valid_i) ? w_onehot : '0;
        bus.ram_read_ready_o = (r_state == GRANT) && bus.ready_i[r_gnt_idx];
        bus.data_o           = w_data;
        bus.burst_done_o     = r_done;
        bus.burst_abort_o    = r_abort;
    end
endmodule
